// File: rtl/gray_monitor.sv
// gray_monitor: decodes a 4-bit Gray sample stream to binary and checks each step.
// Legal steps are +1 (mod 16) and hold. The monitor locks after 4 consecutive
// good steps, and counts illegal steps in a counter that saturates.
// Optional feature macro: GRAY_MON_DOWN_EN also accepts -1 steps and drives dir_down.
module gray_monitor (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] gray_in,
  input  logic       in_valid,
  output logic [3:0] bin_out,
  output logic       bin_valid,
  output logic       step_err,
  output logic [7:0] err_count,
  output logic       locked,
  output logic       dir_down
);

  typedef enum logic [1:0] {IDLE, TRACK, LOCK} state_t;

  state_t     state, state_nxt;
  logic [3:0] prev_bin, prev_nxt, bin_dec;
  logic [2:0] good_cnt, cnt_nxt;
  logic [7:0] err_nxt;
  logic       step_err_nxt;
  logic       is_hold, is_up, is_down, is_good, dir_chg, dir_nxt;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    bin_dec[3] = gray_in[3];
    for (int i = 2; i >= 0; i--) bin_dec[i] = bin_dec[i+1] ^ gray_in[i];
  end

  // Step classification against the previously accepted sample
  always_comb begin
    is_hold = (bin_dec == prev_bin);
    is_up   = (bin_dec == prev_bin + 4'd1);
`ifdef GRAY_MON_DOWN_EN
    is_down = (bin_dec == prev_bin - 4'd1);
    // A good step whose direction differs from the last good step restarts the run
    dir_chg = (is_up && dir_down) || (is_down && !dir_down);
    dir_nxt = is_down ? 1'b1 : (is_up ? 1'b0 : dir_down);
`else
    is_down = 1'b0;
    dir_chg = 1'b0;
    dir_nxt = 1'b0;
`endif
    is_good = is_up || is_down;
  end

  // Next-state logic; everything holds unless a sample is accepted
  always_comb begin
    state_nxt    = state;
    prev_nxt     = prev_bin;
    cnt_nxt      = good_cnt;
    err_nxt      = err_count;
    step_err_nxt = 1'b0;
    if (in_valid) begin
      prev_nxt = bin_dec;
      case (state)
        IDLE: begin
          state_nxt = TRACK;
          cnt_nxt   = 3'd0;
        end
        TRACK, LOCK: begin
          if (is_hold) begin
            cnt_nxt = good_cnt;
          end else if (is_good) begin
            if (dir_chg)               cnt_nxt = 3'd1;
            else if (good_cnt != 3'd4) cnt_nxt = good_cnt + 3'd1;
            if (state == TRACK && cnt_nxt == 3'd4) state_nxt = LOCK;
          end else begin
            step_err_nxt = 1'b1;
            cnt_nxt      = 3'd0;
            state_nxt    = TRACK;
            if (err_count != 8'hFF) err_nxt = err_count + 8'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and output registers; synchronous active-low reset wins over in_valid
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      prev_bin  <= 4'd0;
      good_cnt  <= 3'd0;
      bin_out   <= 4'd0;
      bin_valid <= 1'b0;
      step_err  <= 1'b0;
      err_count <= 8'd0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev_bin  <= prev_nxt;
      good_cnt  <= cnt_nxt;
      bin_valid <= in_valid;
      step_err  <= step_err_nxt;
      err_count <= err_nxt;
      locked    <= (state_nxt == LOCK);
      if (in_valid) bin_out <= bin_dec;
    end
  end

`ifdef GRAY_MON_DOWN_EN
  // Direction of the last good step; holds across stalls and illegal steps
  always_ff @(posedge clk) begin
    if (!rst)                                       dir_down <= 1'b0;
    else if (in_valid && state != IDLE && is_good)  dir_down <= dir_nxt;
  end
`else
  assign dir_down = 1'b0;
`endif

endmodule

// File: doc/gray_monitor.md
GRAY_MONITOR -- requirements
Module: gray_monitor

Interface
REQ-001 SHALL provide ports, clock and reset first:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low
- gray_in  input  4  Gray code sample from the upstream Gray counter
- in_valid  input  1  gray_in valid this cycle
- bin_out  output  4  registered binary equivalent of the last accepted sample
- bin_valid  output  1  one-cycle pulse, bin_out updated
- step_err  output  1  one-cycle pulse, illegal step detected
- err_count  output  8  saturating count of illegal steps
- locked  output  1  sequence tracking is locked
- dir_down  output  1  last good step was a decrement; tied 0 unless GRAY_MON_DOWN_EN

Function
REQ-002 SHALL decode Gray to binary: b3=g3, b2=b3^g2, b1=b2^g1, b0=b1^g0.
REQ-003 SHALL accept a sample only on a clk edge with in_valid=1; with in_valid=0 all state holds and bin_valid=step_err=0.
REQ-004 SHALL register bin_out and pulse bin_valid on the cycle after each accepted sample (latency 1).
REQ-005 SHALL keep prev_bin (4 b) and implement FSM states IDLE, TRACK and LOCK.
REQ-006 IDLE: the first accepted sample loads prev_bin and moves the FSM to TRACK with good_cnt=0; no step check in IDLE.
REQ-007 Good step: new == prev_bin+1 mod 16; 15->0 wrap is good.
REQ-008 Hold step (new == prev_bin) SHALL be a stall: no error, good_cnt unchanged, bin_valid still pulses.
REQ-009 Any other step SHALL be illegal: step_err pulses next cycle, err_count increments, good_cnt clears, FSM goes to TRACK, locked deasserts next cycle.
REQ-010 TRACK: each good step increments good_cnt; the 4th consecutive good step moves the FSM to LOCK, and locked asserts the cycle after that sample.
REQ-011 LOCK: good and hold steps keep LOCK; an illegal step follows REQ-009.
REQ-012 err_count SHALL saturate at 255 and never wrap; step_err still pulses when saturated.
REQ-013 prev_bin SHALL update on every accepted sample, including illegal ones (re-acquire from the new value).
REQ-014 locked SHALL be a registered output equal to (state==LOCK).

Reset
REQ-015 While rst=0 at a clk edge: state=IDLE, prev_bin=0, good_cnt=0, bin_out=0, bin_valid=0, step_err=0, err_count=0, locked=0, dir_down=0.
REQ-016 Reset SHALL take priority over in_valid; reset mid-operation discards history, and the next accepted sample is treated per REQ-006.

Configuration
REQ-017 Macro GRAY_MON_DOWN_EN SHALL control down-count acceptance.
REQ-018 With GRAY_MON_DOWN_EN defined:
- new == prev_bin-1 mod 16 (0->15 wrap included) is also a good step.
- A direction change counts as a good step but restarts good_cnt at 1.
- dir_down registers 1 after a good decrement and 0 after a good increment; it holds on stall and on an illegal step.
REQ-019 Without GRAY_MON_DOWN_EN:
- a decrement is illegal per REQ-009;
- dir_down is constant 0.

Verification
REQ-020 Bench SHALL cover these scenarios:
- rst=0 for 2 cycles -> all outputs 0, locked=0.
- Gray 0000,0001,0011,0010,0110 with in_valid=1 -> bin_out 0,1,2,3,4, each one cycle later; locked=1 the cycle after 0110; step_err never.
- Locked at gray 1000 (15), next 0000 -> bin_out 0, no step_err, locked stays 1.
- Locked at 0001 (1), next 0010 (3) -> step_err one pulse, err_count=1, locked=0 next cycle; 4 further good steps re-lock.
- 300 illegal steps -> err_count=255; repeated 0011 with in_valid gaps -> no error, state held.
- Mid-LOCK rst=0 one cycle, then 0110 -> FSM IDLE->TRACK, no step_err, err_count=0.
- With GRAY_MON_DOWN_EN, 0011->0001 (2->1) -> no error, dir_down=1.
- Without GRAY_MON_DOWN_EN, 0011->0001 -> step_err, dir_down=0.
